// File: rtl/hyperbus_mem_responder_if.sv
// Device-side HyperBus signal bundle between the PHY (master) and the
// memory responder (slave), one 16-bit DDR word per CK cycle.
interface hyperbus_mem_responder_if;
    logic        hyper_cs_ni;
    logic        ck_ena_i;
    logic [15:0] dq_i;
    logic [1:0]  rwds_i;
    logic [15:0] dq_o;
    logic        dq_oe_o;
    logic [1:0]  rwds_o;
    logic        rwds_oe_o;

    modport master (
        output hyper_cs_ni,
        output ck_ena_i,
        output dq_i,
        output rwds_i,
        input  dq_o,
        input  dq_oe_o,
        input  rwds_o,
        input  rwds_oe_o
    );

    modport slave (
        input  hyper_cs_ni,
        input  ck_ena_i,
        input  dq_i,
        input  rwds_i,
        output dq_o,
        output dq_oe_o,
        output rwds_o,
        output rwds_oe_o
    );
endinterface

// File: rtl/hyperbus_mem_responder.sv
// HyperRAM-style memory responder: decodes the 48-bit CA, applies the fixed
// initial latency, then streams read words or stores byte-masked write words.
module hyperbus_mem_responder #(
    parameter int unsigned AddrWidth    = 10,
    parameter int unsigned Latency      = 6,
    parameter bit          ExtraLatency = 1'b1,
    parameter logic [15:0] IdReg0       = 16'h0c81,
    parameter logic [15:0] CfgReg0Init  = 16'h8f1f
) (
    input  logic                    tx_clk_90,
    input  logic                    rst_ni,
    hyperbus_mem_responder_if.slave bus
);
    localparam int unsigned LatCycles = Latency * (ExtraLatency ? 2 : 1);
    localparam logic [3:0]  LatInit   = 4'(LatCycles - 1);
    localparam int unsigned Depth     = 1 << AddrWidth;
    // Address bits above CA[2:0] come from CA[31:16]; valid for AddrWidth 5..19.
    localparam int unsigned PageWidth = AddrWidth - 3;

    typedef enum logic [2:0] {
        IDLE,
        CA,
        LAT,
        READ,
        WRITE,
        REGWR,
        DONE
    } state_e;

    state_e               r_state;
    state_e               w_state_next;
    logic [1:0]           r_ca_cnt;
    logic [1:0]           w_ca_cnt_next;
    logic [2:0]           r_ca_flags;
    logic [2:0]           w_ca_flags_next;
    logic [PageWidth-1:0] r_ca_page;
    logic [PageWidth-1:0] w_ca_page_next;
    logic [AddrWidth-1:0] r_addr;
    logic [AddrWidth-1:0] w_addr_next;
    logic [3:0]           r_lat;
    logic [3:0]           w_lat_next;
    logic                 r_reg_sel;
    logic                 w_reg_sel_next;
    logic [15:0]          r_cr0;
    logic [15:0]          w_cr0_next;
    logic                 r_dq_oe;
    logic                 w_dq_oe_next;
    logic                 r_rwds_oe;
    logic                 w_rwds_oe_next;
    logic [1:0]           r_rwds;
    logic [1:0]           w_rwds_next;
    logic                 r_src_mem;
    logic                 w_src_mem_next;
    logic [15:0]          r_reg_word;
    logic [15:0]          w_reg_word_next;

    logic                 w_active;
    logic                 w_ca_read;
    logic                 w_ca_reg;
    logic                 w_ca_linear;
    logic [AddrWidth-1:0] w_ca_addr;
    logic [AddrWidth-1:0] w_addr_inc;
    logic                 w_mem_re;
    logic                 w_mem_we;
    logic [15:0]          w_mem_rdata;

    assign w_active    = !bus.hyper_cs_ni && bus.ck_ena_i;
    assign w_ca_read   = r_ca_flags[2];
    assign w_ca_reg    = r_ca_flags[1];
    assign w_ca_linear = r_ca_flags[0];
    assign w_ca_addr   = {r_ca_page, bus.dq_i[2:0]};

    // Wrapped bursts stay inside a 16-word (32-byte) aligned group.
    assign w_addr_inc = w_ca_linear ? r_addr + {{(AddrWidth-1){1'b0}}, 1'b1}
                                    : {r_addr[AddrWidth-1:4], r_addr[3:0] + 4'd1};

    always_comb begin
        w_state_next    = r_state;
        w_ca_cnt_next   = r_ca_cnt;
        w_ca_flags_next = r_ca_flags;
        w_ca_page_next  = r_ca_page;
        w_addr_next     = r_addr;
        w_lat_next      = r_lat;
        w_reg_sel_next  = r_reg_sel;
        w_cr0_next      = r_cr0;
        w_dq_oe_next    = r_dq_oe;
        w_rwds_oe_next  = r_rwds_oe;
        w_rwds_next     = r_rwds;
        w_src_mem_next  = r_src_mem;
        w_reg_word_next = r_reg_word;
        w_mem_re        = 1'b0;
        w_mem_we        = 1'b0;

        if (bus.hyper_cs_ni) begin
            w_state_next    = IDLE;
            w_ca_cnt_next   = 2'd0;
            w_dq_oe_next    = 1'b0;
            w_rwds_oe_next  = 1'b0;
            w_rwds_next     = 2'b00;
            w_src_mem_next  = 1'b0;
            w_reg_word_next = 16'h0000;
        end else begin
            unique case (r_state)
                IDLE, CA: begin
                    // RWDS advertises the latency count while CA is being received.
                    w_state_next   = CA;
                    w_rwds_oe_next = 1'b1;
                    w_rwds_next    = {ExtraLatency, ExtraLatency};
                    if (w_active) begin
                        w_ca_cnt_next = r_ca_cnt + 2'd1;
                        unique case (r_ca_cnt)
                            2'd0: w_ca_flags_next = bus.dq_i[15:13];
                            2'd1: w_ca_page_next  = bus.dq_i[PageWidth-1:0];
                            default: begin
                                w_addr_next    = w_ca_addr;
                                w_reg_sel_next = bus.dq_i[0];
                                w_lat_next     = LatInit;
                                w_rwds_oe_next = 1'b0;
                                w_rwds_next    = 2'b00;
                                w_state_next   = (!w_ca_read && w_ca_reg) ? REGWR : LAT;
                            end
                        endcase
                    end
                end
                LAT: begin
                    if (w_active) begin
                        if (r_lat == 4'd0) begin
                            if (w_ca_read) begin
                                // Launch word 0 so it is on the bus during the first data cycle.
                                w_state_next    = READ;
                                w_mem_re        = !w_ca_reg;
                                w_dq_oe_next    = 1'b1;
                                w_rwds_oe_next  = 1'b1;
                                w_rwds_next     = 2'b10;
                                w_src_mem_next  = !w_ca_reg;
                                w_reg_word_next = r_reg_sel ? r_cr0 : IdReg0;
                                w_addr_next     = w_addr_inc;
                            end else begin
                                w_state_next = WRITE;
                            end
                        end else begin
                            w_lat_next = r_lat - 4'd1;
                        end
                    end
                end
                READ: begin
                    if (w_active) begin
                        w_mem_re    = !w_ca_reg;
                        w_addr_next = w_addr_inc;
                    end
                end
                WRITE: begin
                    if (w_active) begin
                        w_mem_we    = 1'b1;
                        w_addr_next = w_addr_inc;
                    end
                end
                REGWR: begin
                    if (w_active) begin
                        w_cr0_next   = bus.dq_i;
                        w_state_next = DONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge tx_clk_90 or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= IDLE;
            r_ca_cnt   <= 2'd0;
            r_ca_flags <= 3'b000;
            r_ca_page  <= '0;
            r_addr     <= '0;
            r_lat      <= 4'd0;
            r_reg_sel  <= 1'b0;
            r_cr0      <= CfgReg0Init;
            r_dq_oe    <= 1'b0;
            r_rwds_oe  <= 1'b0;
            r_rwds     <= 2'b00;
            r_src_mem  <= 1'b0;
            r_reg_word <= 16'h0000;
        end else begin
            r_state    <= w_state_next;
            r_ca_cnt   <= w_ca_cnt_next;
            r_ca_flags <= w_ca_flags_next;
            r_ca_page  <= w_ca_page_next;
            r_addr     <= w_addr_next;
            r_lat      <= w_lat_next;
            r_reg_sel  <= w_reg_sel_next;
            r_cr0      <= w_cr0_next;
            r_dq_oe    <= w_dq_oe_next;
            r_rwds_oe  <= w_rwds_oe_next;
            r_rwds     <= w_rwds_next;
            r_src_mem  <= w_src_mem_next;
            r_reg_word <= w_reg_word_next;
        end
    end

    // One byte-wide array per lane so the RWDS mask maps to a plain write enable.
    for (genvar gi = 0; gi < 2; gi++) begin : g_byte
        logic [7:0] r_mem [Depth];
        logic [7:0] r_rd;

        always_ff @(posedge tx_clk_90) begin
            if (w_mem_we && !bus.rwds_i[gi]) begin
                r_mem[r_addr] <= bus.dq_i[gi*8 +: 8];
            end
            if (w_mem_re) begin
                r_rd <= r_mem[r_addr];
            end
        end
    end

    assign w_mem_rdata   = {g_byte[1].r_rd, g_byte[0].r_rd};
    assign bus.dq_o      = r_src_mem ? w_mem_rdata : r_reg_word;
    assign bus.dq_oe_o   = r_dq_oe;
    assign bus.rwds_o    = r_rwds;
    assign bus.rwds_oe_o = r_rwds_oe;
endmodule

// File: tb/tb_hyperbus_mem_responder.sv
// Randomised bench for hyperbus_mem_responder: drives HyperBus transactions
// and compares every bus cycle against a word-array / CR0 reference model.
module tb_hyperbus_mem_responder;
    localparam int          AW       = 10;
    localparam int          DEPTH    = 1 << AW;
    localparam int          L        = 12;
    localparam logic [15:0] ID0      = 16'h0c81;
    localparam logic [15:0] CR0_INIT = 16'h8f1f;

    logic        tx_clk_90 = 1'b0;
    logic        rst_ni    = 1'b0;
    int          n_vec     = 0;
    int          n_miss    = 0;
    logic [15:0] model_mem [DEPTH];
    logic [15:0] model_cr0 = CR0_INIT;
    logic [15:0] qd [$];
    logic [1:0]  qm [$];

    hyperbus_mem_responder_if bus_if ();

    hyperbus_mem_responder #(
        .AddrWidth    (AW),
        .Latency      (6),
        .ExtraLatency (1'b1),
        .IdReg0       (ID0),
        .CfgReg0Init  (CR0_INIT)
    ) dut (
        .tx_clk_90 (tx_clk_90),
        .rst_ni    (rst_ni),
        .bus       (bus_if.slave)
    );

    always #5 tx_clk_90 = ~tx_clk_90;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int word_addr(input int base, input bit lin, input int i);
        if (lin) return (base + i) % DEPTH;
        return (base & ~15) | ((base + i) & 15);
    endfunction

    function automatic logic [15:0] exp_word(input bit rs, input bit lin, input int addr, input int i);
        if (rs) return (addr % 2 == 1) ? model_cr0 : ID0;
        return model_mem[word_addr(addr, lin, i)];
    endfunction

    // Outputs visible while the inputs of active cycle n are presented.
    task automatic expect_outputs(input string name, input int n, input bit rd, input bit rs,
                                  input bit lin, input int addr);
        logic [3:0] ctl;
        ctl = {bus_if.dq_oe_o, bus_if.rwds_oe_o, bus_if.rwds_o};
        if (n == 0) begin
            check_eq($sformatf("%s n=%0d oe", name, n), ctl[3:2], 2'b00);
        end else if (n <= 2) begin
            check_eq($sformatf("%s n=%0d ca_ctl", name, n), ctl, 4'b0111);
        end else if (rd && n >= 3 + L) begin
            check_eq($sformatf("%s n=%0d rd_ctl", name, n), ctl, 4'b1110);
            check_eq($sformatf("%s n=%0d dq", name, n), bus_if.dq_o, exp_word(rs, lin, addr, n - 3 - L));
        end else begin
            check_eq($sformatf("%s n=%0d oe", name, n), ctl[3:2], 2'b00);
        end
    endtask

    task automatic run_xact(input string name, input bit rd, input bit rs, input bit lin,
                            input int addr, input int nw, input int stop_at,
                            input int gap_pct, input int gap_at, input bit rst_end);
        logic [15:0] ca [3];
        logic [15:0] d;
        logic [1:0]  m;
        int total, n, i, a, gaps, miss0;
        miss0 = n_miss;
        ca[0] = {rd, rs, lin, 13'($urandom)};
        ca[1] = {9'($urandom), 7'(addr >> 3)};
        ca[2] = {13'($urandom), 3'(addr)};
        total = (rs && !rd) ? 3 + nw : 3 + L + nw;
        if (stop_at >= 0) total = stop_at;
        n = 0;
        gaps = 0;
        while (n < total) begin
            @(negedge tx_clk_90);
            expect_outputs(name, n, rd, rs, lin, addr);
            bus_if.hyper_cs_ni = 1'b0;
            if (n > 0 && ((n == gap_at && gaps < 5) || $urandom_range(99) < gap_pct)) begin
                if (n == gap_at) gaps++;
                bus_if.ck_ena_i = 1'b0;
                bus_if.dq_i     = 16'($urandom);
                bus_if.rwds_i   = 2'($urandom);
            end else begin
                bus_if.ck_ena_i = 1'b1;
                if (n < 3) begin
                    bus_if.dq_i   = ca[n];
                    bus_if.rwds_i = 2'($urandom);
                end else begin
                    i = (rs && !rd) ? n - 3 : n - 3 - L;
                    d = (i >= 0 && i < qd.size()) ? qd[i] : 16'($urandom);
                    m = (i >= 0 && i < qm.size()) ? qm[i] : 2'b00;
                    bus_if.dq_i   = d;
                    bus_if.rwds_i = m;
                    if (!rd && i >= 0) begin
                        if (rs) begin
                            if (i == 0) model_cr0 = d;
                        end else begin
                            a = word_addr(addr, lin, i);
                            if (!m[1]) model_mem[a][15:8] = d[15:8];
                            if (!m[0]) model_mem[a][7:0]  = d[7:0];
                        end
                    end
                end
                n++;
            end
        end
        @(negedge tx_clk_90);
        expect_outputs(name, n, rd, rs, lin, addr);
        if (rst_end) begin
            bus_if.ck_ena_i = 1'b1;
            bus_if.dq_i     = 16'($urandom);
            bus_if.rwds_i   = 2'b00;
            #2 rst_ni = 1'b0;
            #1;
            check_eq({name, " async_rst_ctl"}, {bus_if.dq_oe_o, bus_if.rwds_oe_o, bus_if.rwds_o}, 4'b0000);
            check_eq({name, " async_rst_dq"}, bus_if.dq_o, 16'h0000);
            model_cr0 = CR0_INIT;
            @(negedge tx_clk_90);
            bus_if.hyper_cs_ni = 1'b1;
            rst_ni = 1'b1;
        end else begin
            bus_if.hyper_cs_ni = 1'b1;
            bus_if.ck_ena_i    = 1'($urandom);
        end
        @(negedge tx_clk_90);
        check_eq({name, " cs_high_oe"}, {bus_if.dq_oe_o, bus_if.rwds_oe_o}, 2'b00);
        $display("xact %-10s rd=%0d reg=%0d lin=%0d addr=%03h words=%0d active=%0d miscompares=%0d",
                 name, rd, rs, lin, addr, nw, total, n_miss - miss0);
    endtask

    initial begin
        int kind, a, nw;
        bit lin;
        bus_if.hyper_cs_ni = 1'b1;
        bus_if.ck_ena_i    = 1'b0;
        bus_if.dq_i        = 16'h0000;
        bus_if.rwds_i      = 2'b00;
        repeat (2) @(negedge tx_clk_90);
        check_eq("reset ctl", {bus_if.dq_oe_o, bus_if.rwds_oe_o, bus_if.rwds_o}, 4'b0000);
        check_eq("reset dq", bus_if.dq_o, 16'h0000);
        rst_ni = 1'b1;

        qd.delete();
        qm.delete();
        run_xact("cr0_init", 1, 1, 1, 1, 2, -1, 0, -1, 0);
        for (int k = 0; k < DEPTH; k++) qd.push_back(16'($urandom));
        run_xact("fill", 0, 0, 1, 0, DEPTH, -1, 0, -1, 0);

        qd = {16'h1111, 16'h2222, 16'h3333, 16'h4444};
        run_xact("lin_wr", 0, 0, 1, 'h010, 4, -1, 0, -1, 0);
        run_xact("lin_rd", 1, 0, 1, 'h010, 4, -1, 0, -1, 0);

        qd = {16'h5566};
        run_xact("preload", 0, 0, 1, 'h020, 1, -1, 0, -1, 0);
        qd = {16'habcd};
        qm = {2'b01};
        run_xact("mask_wr", 0, 0, 1, 'h020, 1, -1, 0, -1, 0);
        qm.delete();
        run_xact("mask_rd", 1, 0, 1, 'h020, 1, -1, 0, -1, 0);

        run_xact("wrap_rd", 1, 0, 0, 'h01e, 4, -1, 0, -1, 0);
        run_xact("lin_top", 1, 0, 1, 'h3ff, 2, -1, 0, -1, 0);

        run_xact("id_rd", 1, 1, 1, 0, 2, -1, 0, -1, 0);
        qd = {16'h1234, 16'hdead, 16'hbeef};
        run_xact("cr0_wr", 0, 1, 1, 1, 3, -1, 0, -1, 0);
        run_xact("cr0_rd", 1, 1, 1, 1, 2, -1, 0, -1, 0);

        run_xact("gap_rd", 1, 0, 1, 'h010, 6, -1, 0, 3 + L + 2, 0);

        qd = {16'h0bad, 16'hf00d, 16'hcafe, 16'h7777};
        run_xact("abort_wr", 0, 0, 1, 'h040, 4, 2, 0, -1, 0);
        run_xact("abort_rd", 1, 0, 1, 'h040, 1, -1, 0, -1, 0);

        qd = {16'ha0a0, 16'ha1a1, 16'ha2a2, 16'ha3a3};
        run_xact("rst_wr", 0, 0, 1, 'h050, 4, 3 + L + 2, 0, -1, 1);
        run_xact("rst_wr_rd", 1, 0, 1, 'h050, 4, -1, 0, -1, 0);
        run_xact("rst_rd", 1, 0, 1, 'h100, 4, 3 + L + 2, 0, -1, 1);
        run_xact("cr0_rst", 1, 1, 1, 1, 2, -1, 0, -1, 0);

        for (int t = 0; t < 40; t++) begin
            kind = $urandom_range(9);
            a    = $urandom_range(DEPTH - 1);
            nw   = $urandom_range(8, 1);
            lin  = 1'($urandom);
            qd.delete();
            qm.delete();
            for (int k = 0; k < nw; k++) begin
                qd.push_back(16'($urandom));
                qm.push_back(2'($urandom));
            end
            if (kind < 4)       run_xact("rnd_wr", 0, 0, lin, a, nw, -1, 20, -1, 0);
            else if (kind < 8)  run_xact("rnd_rd", 1, 0, lin, a, nw, -1, 20, -1, 0);
            else if (kind == 8) run_xact("rnd_regrd", 1, 1, lin, a, nw, -1, 20, -1, 0);
            else                run_xact("rnd_regwr", 0, 1, lin, a, nw, -1, 20, -1, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
